// File: rtl/shift_scheduler.sv
// shift_scheduler
//
// Round-robin front end for one shared 32-bit combinational barrel shifter.
// Up to NUM_REQ requesters present valid/op/amount/data. One winner is accepted
// per transaction. Its operands are registered onto the sh_* outputs, which
// feed the shared shifter. The shifter result is registered one cycle later
// and returned on a single response channel, tagged with the winner's index.
//
// Ports
//   clk_in         clock, rising edge
//   rst_n_in       synchronous reset, active low
//   req_valid_in   per-requester request valid            [NUM_REQ]
//   req_ready_out  per-requester accept, one-hot or zero  [NUM_REQ]
//   req_op_in      op of requester i at [2i+1:2i]         (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   req_amount_in  shift amount of requester i at [5i+4:5i]
//   req_data_in    operand of requester i at [32i+31:32i]
//   rsp_valid_out  result valid
//   rsp_ready_in   consumer accepts result
//   rsp_id_out     index of the requester that owns the result
//   rsp_data_out   shifted result
//   sh_b_out       registered operand to the shared shifter
//   sh_amount_out  registered shift amount to the shared shifter
//   sh_op_out      registered op to the shared shifter
//   sh_result_in   combinational result from the shared shifter
//   busy_out       high whenever the scheduler is not idle
module shift_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [NUM_REQ-1:0]    req_valid_in,
  output logic [NUM_REQ-1:0]    req_ready_out,
  input  logic [2*NUM_REQ-1:0]  req_op_in,
  input  logic [5*NUM_REQ-1:0]  req_amount_in,
  input  logic [32*NUM_REQ-1:0] req_data_in,
  output logic                  rsp_valid_out,
  input  logic                  rsp_ready_in,
  output logic [ID_W-1:0]       rsp_id_out,
  output logic [31:0]           rsp_data_out,
  output logic [31:0]           sh_b_out,
  output logic [4:0]            sh_amount_out,
  output logic [1:0]            sh_op_out,
  input  logic [31:0]           sh_result_in,
  output logic                  busy_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] rr_next;
  logic            found;
  int              idx;

  // Search upward from the round-robin pointer with wrap-around. The first
  // valid requester found wins, so a lone requester is always granted and
  // idx never leaves 0..NUM_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid_in[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // The pointer moves to the slot just past the winner, so a requester that
  // stays valid cannot be granted again until every other valid one has had
  // a turn.
  always_comb begin
    rr_next = winner + 1'b1;
    if (int'(winner) == NUM_REQ - 1) begin
      rr_next = '0;
    end
  end

  // Grants are only offered while idle. This also blocks an accept in the
  // same cycle as the response handshake, because that cycle is still RESP.
  always_comb begin
    req_ready_out = '0;
    if (state == IDLE && found) begin
      req_ready_out[winner] = 1'b1;
    end
  end

  assign rsp_valid_out = (state == RESP);
  assign busy_out      = (state != IDLE);

  // sh_* are written only on an accept edge, so the shared shifter sees
  // stable inputs for the whole EXEC cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      sh_b_out      <= '0;
      sh_amount_out <= '0;
      sh_op_out     <= '0;
      rsp_id_out    <= '0;
      rsp_data_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sh_op_out     <= req_op_in[2*winner +: 2];
            sh_amount_out <= req_amount_in[5*winner +: 5];
            sh_b_out      <= req_data_in[32*winner +: 32];
            rsp_id_out    <= winner;
            rr_ptr        <= rr_next;
            state         <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_out <= sh_result_in;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready_in) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_scheduler.sv
// Testbench for shift_scheduler with two requesters. A behavioural shifter
// stands in for the shared shifter instance. Expected responses are pushed
// to a scoreboard queue when requests are driven. A monitor pops and compares
// them on every response handshake.
module tb_shift_scheduler;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic                  clk_in;
  logic                  rst_n_in;
  logic [NUM_REQ-1:0]    req_valid_in;
  logic [NUM_REQ-1:0]    req_ready_out;
  logic [2*NUM_REQ-1:0]  req_op_in;
  logic [5*NUM_REQ-1:0]  req_amount_in;
  logic [32*NUM_REQ-1:0] req_data_in;
  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic [ID_W-1:0]       rsp_id_out;
  logic [31:0]           rsp_data_out;
  logic [31:0]           sh_b_out;
  logic [4:0]            sh_amount_out;
  logic [1:0]            sh_op_out;
  logic [31:0]           sh_result_in;
  logic                  busy_out;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   checkCount = 0;
  int   errorCount = 0;

  shift_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_op_in     (req_op_in),
    .req_amount_in (req_amount_in),
    .req_data_in   (req_data_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_id_out    (rsp_id_out),
    .rsp_data_out  (rsp_data_out),
    .sh_b_out      (sh_b_out),
    .sh_amount_out (sh_amount_out),
    .sh_op_out     (sh_op_out),
    .sh_result_in  (sh_result_in),
    .busy_out      (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Stand-in for the shared combinational barrel shifter.
  logic [63:0] rotWide;
  always_comb begin
    rotWide      = {sh_b_out, sh_b_out} >> sh_amount_out;
    sh_result_in = rotWide[31:0];
    case (sh_op_out)
      OP_SLL:  sh_result_in = sh_b_out << sh_amount_out;
      OP_SRL:  sh_result_in = sh_b_out >> sh_amount_out;
      OP_SRA:  sh_result_in = $signed(sh_b_out) >>> sh_amount_out;
      default: sh_result_in = rotWide[31:0];
    endcase
  end

  // Reference result computed bit by bit. It is written independently of the
  // shift-operator shifter above.
  function automatic logic [31:0] refShift(input logic [1:0] op, input int k, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (op)
        OP_SLL:  r[i] = (i >= k) ? b[i-k] : 1'b0;
        OP_SRL:  r[i] = (i + k <= 31) ? b[i+k] : 1'b0;
        OP_SRA:  r[i] = (i + k <= 31) ? b[i+k] : b[31];
        default: r[i] = b[(i+k)%32];
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Raise valid with the given payload. Optionally queue the expected response.
  task automatic applyStimulus(input int id, input logic [1:0] op, input int amt,
                               input logic [31:0] data, input bit push);
    rsp_t e;
    req_op_in[2*id +: 2]      = op;
    req_amount_in[5*id +: 5]  = amt[4:0];
    req_data_in[32*id +: 32]  = data;
    req_valid_in[id]          = 1'b1;
    if (push) begin
      e.id   = id;
      e.data = refShift(op, amt, data);
      sb.push_back(e);
    end
  endtask

  // Called on or just after a negedge. Returns on the negedge after the
  // accept edge, with valid already dropped.
  task automatic waitAccept(input int id);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 60 && !accepted; i++) begin
      #1;
      if (req_ready_out[id]) begin
        accepted = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid_in[id] = 1'b0;
      end else begin
        @(negedge clk_in);
      end
    end
    checkOutput($sformatf("accept%0d", id), 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk_in);
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic runOne(input int id, input logic [1:0] op, input int amt, input logic [31:0] data);
    @(negedge clk_in);
    applyStimulus(id, op, amt, data, 1'b1);
    waitAccept(id);
    drain();
  endtask

  // Monitor runs mid-low-phase, after inputs have settled for the coming
  // edge. A visible valid&ready means a handshake at the next posedge.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk_in);
      #2;
      checkOutput("ready_onehot", 32'($countones(req_ready_out) <= 1), 32'd1);
      if (rst_n_in && rsp_valid_out && rsp_ready_in) begin
        if (sb.size() == 0) begin
          checkOutput("stray_rsp", 32'(rsp_valid_out), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_id", 32'(rsp_id_out), 32'(e.id));
          checkOutput("rsp_data", rsp_data_out, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_in      = 1'b0;
    req_valid_in  = '0;
    req_op_in     = '0;
    req_amount_in = '0;
    req_data_in   = '0;
    rsp_ready_in  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk_in);
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_rsp_data", rsp_data_out, 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id_out), 32'd0);
    checkOutput("rst_sh_b", sh_b_out, 32'd0);
    checkOutput("rst_sh_amount", 32'(sh_amount_out), 32'd0);
    checkOutput("rst_sh_op", 32'(sh_op_out), 32'd0);
    checkOutput("rst_ready", 32'(req_ready_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Single SLL with latency check: EXEC for one cycle, then RESP
    @(negedge clk_in);
    applyStimulus(0, OP_SLL, 4, 32'h0000_00F1, 1'b1);
    #1;
    checkOutput("ready0", 32'(req_ready_out), 32'h1);
    waitAccept(0);
    #1;
    checkOutput("lat_exec_valid", 32'(rsp_valid_out), 32'd0);
    checkOutput("exec_busy", 32'(busy_out), 32'd1);
    checkOutput("sh_b", sh_b_out, 32'h0000_00F1);
    checkOutput("sh_amount", 32'(sh_amount_out), 32'd4);
    checkOutput("sh_op", 32'(sh_op_out), 32'(OP_SLL));
    @(negedge clk_in);
    #1;
    checkOutput("lat_resp_valid", 32'(rsp_valid_out), 32'd1);
    drain();

    // Ops and amount boundaries (0 and 31)
    runOne(1, OP_SRA, 8,  32'h8000_1234);
    runOne(1, OP_SRL, 8,  32'h8000_1234);
    runOne(0, OP_ROR, 1,  32'h0000_0003);
    runOne(0, OP_ROR, 0,  32'hDEAD_BEEF);
    runOne(1, OP_SLL, 0,  32'hCAFE_F00D);
    runOne(0, OP_SLL, 31, 32'h0000_0001);
    runOne(1, OP_SRA, 31, 32'h8000_0000);
    runOne(0, OP_SRL, 31, 32'h8000_0000);
    runOne(1, OP_ROR, 31, 32'h8000_0001);
    runOne(0, OP_SRA, 5,  32'h7000_00F0);

    // Fairness: reset the pointer, keep both requesters valid for 4 ops
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    begin
      rsp_t e;
      e.id = 0; e.data = refShift(OP_SLL, 1, 32'h0000_0011); sb.push_back(e);
      e.id = 1; e.data = refShift(OP_SRA, 3, 32'hF000_0080); sb.push_back(e);
      e.id = 0; e.data = refShift(OP_SRL, 2, 32'h0000_00F0); sb.push_back(e);
      e.id = 1; e.data = refShift(OP_ROR, 4, 32'h1234_5678); sb.push_back(e);
    end
    fork
      begin
        applyStimulus(0, OP_SLL, 1, 32'h0000_0011, 1'b0);
        waitAccept(0);
        applyStimulus(0, OP_SRL, 2, 32'h0000_00F0, 1'b0);
        waitAccept(0);
      end
      begin
        applyStimulus(1, OP_SRA, 3, 32'hF000_0080, 1'b0);
        waitAccept(1);
        applyStimulus(1, OP_ROR, 4, 32'h1234_5678, 1'b0);
        waitAccept(1);
      end
    join
    drain();

    // Back-pressure: response held, no grant until the handshake
    rsp_ready_in = 1'b0;
    @(negedge clk_in);
    applyStimulus(0, OP_SLL, 1, 32'h0000_0002, 1'b1);
    waitAccept(0);
    @(negedge clk_in);
    applyStimulus(1, OP_SRL, 4, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("hold_valid", 32'(rsp_valid_out), 32'd1);
      checkOutput("hold_id", 32'(rsp_id_out), 32'd0);
      checkOutput("hold_data", rsp_data_out, 32'h0000_0004);
      checkOutput("hold_no_ready", 32'(req_ready_out), 32'd0);
      @(negedge clk_in);
    end
    rsp_ready_in = 1'b1;
    @(negedge clk_in);
    #1;
    checkOutput("idle_after_hs", 32'(busy_out), 32'd0);
    checkOutput("ready1_after_hs", 32'(req_ready_out), 32'h2);
    waitAccept(1);
    drain();

    // Reset during EXEC drops the transaction and clears the pointer
    @(negedge clk_in);
    applyStimulus(1, OP_SLL, 3, 32'h0000_0007, 1'b0);
    waitAccept(1);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    checkOutput("rst_exec_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_exec_valid", 32'(rsp_valid_out), 32'd0);
    checkOutput("rst_exec_data", rsp_data_out, 32'd0);
    checkOutput("rst_exec_sh_b", sh_b_out, 32'd0);
    applyStimulus(0, OP_SRL, 1, 32'h0000_0010, 1'b1);
    applyStimulus(1, OP_SLL, 2, 32'h0000_0003, 1'b1);
    #1;
    checkOutput("rr_after_rst", 32'(req_ready_out), 32'h1);
    fork
      waitAccept(0);
      waitAccept(1);
    join
    drain();
    repeat (10) @(negedge clk_in);
    checkOutput("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
